// File: rtl/conv_tile_dispatcher.sv
// rtl/conv_tile_dispatcher.sv - splits a convolution job into NMCU waves and drives lane addresses/starts
// Optional DISPATCH_PERF_EN adds perf_cycles/perf_waves job counters.
module conv_tile_dispatcher #(
   parameter  int ADDR_WIDTH     = 16,
   parameter  int NUM_NMCUS      = 9,
   parameter  int MAX_INPUT_DIM  = 15,
   parameter  int MAX_KERNEL_DIM = 7,
   localparam int DW             = $clog2(MAX_INPUT_DIM) + 1,
   localparam int KW             = $clog2(MAX_KERNEL_DIM) + 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [ADDR_WIDTH-1:0]           cmd_input_base,
   input  logic [ADDR_WIDTH-1:0]           cmd_output_base,
   input  logic [DW-1:0]                   cmd_input_width,
   input  logic [DW-1:0]                   cmd_input_height,
   input  logic [KW-1:0]                   cmd_kernel_dim,
   input  logic [ADDR_WIDTH-1:0]           cmd_desc,
   output logic [ADDR_WIDTH-1:0]           nmcu_desc,
   output logic [NUM_NMCUS*ADDR_WIDTH-1:0] input_addr,
   output logic [NUM_NMCUS*ADDR_WIDTH-1:0] output_addr,
   output logic [DW-1:0]                   full_input_width,
   output logic [DW-1:0]                   full_input_height,
   output logic [DW-1:0]                   full_output_width,
   output logic [DW-1:0]                   full_output_height,
   output logic [NUM_NMCUS-1:0]            start,
   input  logic [NUM_NMCUS-1:0]            done,
   output logic                            busy,
   output logic                            job_done,
   output logic                            job_err
`ifdef DISPATCH_PERF_EN
   ,
   output logic [31:0]                     perf_cycles,
   output logic [7:0]                      perf_waves
`endif
);
   localparam int LW = (NUM_NMCUS > 1) ? $clog2(NUM_NMCUS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_ASSIGN, S_ISSUE, S_WAIT, S_RELEASE, S_FINISH
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_in_base, r_out_base, r_desc;
   logic [DW-1:0]         r_w, r_h, r_ow, r_oh, r_row, r_col;
   logic [KW-1:0]         r_k;
   logic [LW-1:0]         r_lane;
   logic [NUM_NMCUS-1:0]  r_mask, r_seen, r_start;
   logic [ADDR_WIDTH-1:0] r_in_addr  [NUM_NMCUS];
   logic [ADDR_WIDTH-1:0] r_out_addr [NUM_NMCUS];
   logic                  r_more, r_err, r_job_done, r_job_err;

   logic                  w_bad, w_last_pix, w_last_lane;
   logic [DW-1:0]         w_ow, w_oh;
   logic [ADDR_WIDTH-1:0] w_in_addr, w_out_addr;
   logic [NUM_NMCUS-1:0]  w_seen_nxt;

   assign w_bad = (r_k == '0) || (r_k > KW'(MAX_KERNEL_DIM))
                || (r_w > DW'(MAX_INPUT_DIM)) || (r_h > DW'(MAX_INPUT_DIM))
                || (DW'(r_k) > r_w) || (DW'(r_k) > r_h);
   assign w_ow        = r_w - DW'(r_k) + DW'(1);
   assign w_oh        = r_h - DW'(r_k) + DW'(1);
   assign w_last_pix  = (r_row == r_oh - DW'(1)) && (r_col == r_ow - DW'(1));
   assign w_last_lane = (r_lane == LW'(NUM_NMCUS - 1));
   // Address arithmetic is deliberately modulo 2^ADDR_WIDTH.
   assign w_in_addr  = r_in_base + ADDR_WIDTH'(r_row) * ADDR_WIDTH'(r_w) + ADDR_WIDTH'(r_col);
   assign w_out_addr = r_out_base + ADDR_WIDTH'(r_row) * ADDR_WIDTH'(r_ow) + ADDR_WIDTH'(r_col);
   assign w_seen_nxt = r_seen | (done & r_mask);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_in_base  <= '0;
         r_out_base <= '0;
         r_desc     <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_ow       <= '0;
         r_oh       <= '0;
         r_k        <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_lane     <= '0;
         r_mask     <= '0;
         r_seen     <= '0;
         r_start    <= '0;
         r_more     <= 1'b0;
         r_err      <= 1'b0;
         r_job_done <= 1'b0;
         r_job_err  <= 1'b0;
         for (int i = 0; i < NUM_NMCUS; i++) begin
            r_in_addr[i]  <= '0;
            r_out_addr[i] <= '0;
         end
      end else begin
         r_job_done <= 1'b0;
         r_job_err  <= 1'b0;
         case (r_state)
            S_IDLE: if (cmd_valid) begin
               r_in_base  <= cmd_input_base;
               r_out_base <= cmd_output_base;
               r_desc     <= cmd_desc;
               r_w        <= cmd_input_width;
               r_h        <= cmd_input_height;
               r_k        <= cmd_kernel_dim;
               r_err      <= 1'b0;
               r_state    <= S_CHECK;
            end
            S_CHECK: begin
               if (w_bad) begin
                  r_err      <= 1'b1;
                  r_job_done <= 1'b1;
                  r_job_err  <= 1'b1;
                  r_state    <= S_FINISH;
               end else begin
                  r_ow    <= w_ow;
                  r_oh    <= w_oh;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_lane  <= '0;
                  r_mask  <= '0;
                  for (int i = 0; i < NUM_NMCUS; i++) begin
                     r_in_addr[i]  <= '0;
                     r_out_addr[i] <= '0;
                  end
                  r_state <= S_ASSIGN;
               end
            end
            S_ASSIGN: begin
               r_in_addr[r_lane]  <= w_in_addr;
               r_out_addr[r_lane] <= w_out_addr;
               r_mask[r_lane]     <= 1'b1;
               if (r_col == r_ow - DW'(1)) begin
                  r_col <= '0;
                  r_row <= r_row + DW'(1);
               end else begin
                  r_col <= r_col + DW'(1);
               end
               if (w_last_pix || w_last_lane) begin
                  r_more  <= !w_last_pix;
                  r_lane  <= '0;
                  r_state <= S_ISSUE;
               end else begin
                  r_lane <= r_lane + LW'(1);
               end
            end
            S_ISSUE: begin
               r_start <= r_mask;
               r_seen  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_seen  <= w_seen_nxt;
               r_start <= r_mask & ~w_seen_nxt;
               if (w_seen_nxt == r_mask) r_state <= S_RELEASE;
            end
            S_RELEASE: begin
               r_start <= '0;
               // Hold until every active done drops so a stale level cannot finish the next wave.
               if ((done & r_mask) == '0) begin
                  if (r_more) begin
                     r_mask <= '0;
                     r_lane <= '0;
                     for (int i = 0; i < NUM_NMCUS; i++) begin
                        r_in_addr[i]  <= '0;
                        r_out_addr[i] <= '0;
                     end
                     r_state <= S_ASSIGN;
                  end else begin
                     r_job_done <= 1'b1;
                     r_job_err  <= r_err;
                     r_state    <= S_FINISH;
                  end
               end
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_NMCUS; k++) begin : g_pack
      assign input_addr[k*ADDR_WIDTH +: ADDR_WIDTH]  = r_in_addr[k];
      assign output_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = r_out_addr[k];
   end

   assign cmd_ready          = (r_state == S_IDLE);
   assign busy               = (r_state != S_IDLE);
   assign start              = r_start;
   assign job_done           = r_job_done;
   assign job_err            = r_job_err;
   assign nmcu_desc          = r_desc;
   assign full_input_width   = r_w;
   assign full_input_height  = r_h;
   assign full_output_width  = r_ow;
   assign full_output_height = r_oh;

`ifdef DISPATCH_PERF_EN
   logic [31:0] r_perf_cycles;
   logic [7:0]  r_perf_waves;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_perf_cycles <= '0;
         r_perf_waves  <= '0;
      end else if (r_state == S_IDLE) begin
         if (cmd_valid) begin
            r_perf_cycles <= '0;
            r_perf_waves  <= '0;
         end
      end else begin
         if (r_perf_cycles != 32'hFFFF_FFFF) r_perf_cycles <= r_perf_cycles + 32'd1;
         if (r_state == S_ISSUE) r_perf_waves <= r_perf_waves + 8'd1;
      end
   end

   assign perf_cycles = r_perf_cycles;
   assign perf_waves  = r_perf_waves;
`endif
endmodule

// File: tb/tb_conv_tile_dispatcher.sv
// tb/tb_conv_tile_dispatcher.sv - self-checking bench for conv_tile_dispatcher
module tb_conv_tile_dispatcher;
   localparam int AW = 16;
   localparam int N  = 9;
   localparam int DW = 5;
   localparam int KW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_input_base = '0, cmd_output_base = '0, cmd_desc = '0;
   logic [DW-1:0]   cmd_input_width = '0, cmd_input_height = '0;
   logic [KW-1:0]   cmd_kernel_dim = '0;
   logic [AW-1:0]   nmcu_desc;
   logic [N*AW-1:0] input_addr, output_addr;
   logic [DW-1:0]   full_input_width, full_input_height, full_output_width, full_output_height;
   logic [N-1:0]    start;
   logic [N-1:0]    done = '0;
   logic            busy, job_done, job_err;

   always #5 clk = ~clk;

   conv_tile_dispatcher #(.ADDR_WIDTH(AW), .NUM_NMCUS(N), .MAX_INPUT_DIM(15), .MAX_KERNEL_DIM(7)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_input_base(cmd_input_base), .cmd_output_base(cmd_output_base),
      .cmd_input_width(cmd_input_width), .cmd_input_height(cmd_input_height),
      .cmd_kernel_dim(cmd_kernel_dim), .cmd_desc(cmd_desc), .nmcu_desc(nmcu_desc),
      .input_addr(input_addr), .output_addr(output_addr),
      .full_input_width(full_input_width), .full_input_height(full_input_height),
      .full_output_width(full_output_width), .full_output_height(full_output_height),
      .start(start), .done(done), .busy(busy), .job_done(job_done), .job_err(job_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the job is a flat list of output pixels in raster order, cut into N-wide waves.
   int m_w, m_h, m_k, m_in, m_out, m_ow, m_oh, m_npix;
   bit m_err;

   function automatic int exp_waves();
      return m_err ? 0 : (m_npix + N - 1) / N;
   endfunction

   function automatic logic [AW-1:0] exp_in(input int wv, input int lane);
      int p = wv * N + lane;
      if (p >= m_npix) return '0;
      return AW'(m_in + (p / m_ow) * m_w + (p % m_ow));
   endfunction

   function automatic logic [AW-1:0] exp_out(input int wv, input int lane);
      int p = wv * N + lane;
      if (p >= m_npix) return '0;
      return AW'(m_out + p);
   endfunction

   function automatic logic [N-1:0] exp_mask(input int wv);
      logic [N-1:0] m = '0;
      for (int l = 0; l < N; l++) if (wv * N + l < m_npix) m[l] = 1'b1;
      return m;
   endfunction

   // NMCU lane emulation: done rises lat[k] cycles after start, falls after start drops unless held.
   int           lat [N];
   int           cnt [N];
   logic [N-1:0] hold_mask = '0;

   initial begin
      for (int k = 0; k < N; k++) cnt[k] = 0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (start[k]) begin
               if (!done[k]) begin
                  cnt[k]++;
                  if (cnt[k] >= lat[k]) done[k] = 1'b1;
               end
            end else begin
               cnt[k] = 0;
               if (!hold_mask[k]) done[k] = 1'b0;
            end
         end
      end
   end

   int           wave_idx = -1;
   logic [N-1:0] prev_start = '0;

   always @(negedge clk) begin
      if (!rst) begin
         prev_start = '0;
      end else begin
         if (start != '0) begin
            if (prev_start == '0) begin
               wave_idx++;
               check("wave_mask", 32'(start), 32'(exp_mask(wave_idx)));
               check("stale_done", 32'(done & exp_mask(wave_idx)), 32'd0);
            end
            check("start_subset", 32'(start & ~exp_mask(wave_idx)), 32'd0);
            for (int k = 0; k < N; k++) begin
               check($sformatf("in_addr[%0d]", k), 32'(input_addr[k*AW +: AW]), 32'(exp_in(wave_idx, k)));
               check($sformatf("out_addr[%0d]", k), 32'(output_addr[k*AW +: AW]), 32'(exp_out(wave_idx, k)));
            end
            check("full_out_w", 32'(full_output_width), 32'(m_ow));
            check("full_out_h", 32'(full_output_height), 32'(m_oh));
            check("full_in_w", 32'(full_input_width), 32'(m_w));
         end
         if (job_done) begin
            check("job_err", 32'(job_err), 32'(m_err));
            check("wave_count", 32'(wave_idx + 1), 32'(exp_waves()));
         end
         prev_start = start;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic submit(input int w, input int h, input int k, input int inb, input int outb, input int desc);
      int t = 0;
      m_w = w; m_h = h; m_k = k; m_in = inb; m_out = outb;
      m_err = (k == 0) || (k > 7) || (w > 15) || (h > 15) || (k > w) || (k > h);
      m_ow = m_err ? 0 : w - k + 1;
      m_oh = m_err ? 0 : h - k + 1;
      m_npix = m_ow * m_oh;
      wave_idx = -1;
      cmd_input_width  = DW'(w);
      cmd_input_height = DW'(h);
      cmd_kernel_dim   = KW'(k);
      cmd_input_base   = AW'(inb);
      cmd_output_base  = AW'(outb);
      cmd_desc         = AW'(desc);
      cmd_valid = 1'b1;
      while (!cmd_ready && t < 100) begin tick(); t++; end
      check("accept_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input int limit);
      int t = 0;
      while (start == '0 && t < limit) begin tick(); t++; end
      check("start_seen", 32'(start != '0), 32'd1);
   endtask

   task automatic wait_done(input int limit);
      int t = 0;
      while (!job_done && t < limit) begin tick(); t++; end
      check("job_done_seen", 32'(job_done), 32'd1);
      tick();
   endtask

   initial begin
      for (int k = 0; k < N; k++) lat[k] = 2 + k;
      rst = 1'b0;
      repeat (3) tick();
      check("rst_start", 32'(start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_job_done", 32'(job_done), 32'd0);
      check("rst_job_err", 32'(job_err), 32'd0);
      check("rst_addr_zero", 32'((input_addr == '0) && (output_addr == '0)), 32'd1);
      check("rst_desc", 32'(nmcu_desc), 32'd0);
      check("rst_dims", 32'({full_input_width, full_output_height}), 32'd0);
      rst = 1'b1;
      tick();
      check("ready_after_rst", 32'(cmd_ready), 32'd1);

      // 6x6 K=4: single full wave, literal lane addresses.
      submit(6, 6, 4, 'h0100, 'h0200, 'hABCD);
      wait_start(50);
      check("j1_start", 32'(start), 32'h1FF);
      check("j1_in3", 32'(input_addr[3*AW +: AW]), 32'h0106);
      check("j1_in8", 32'(input_addr[8*AW +: AW]), 32'h010E);
      check("j1_out8", 32'(output_addr[8*AW +: AW]), 32'h0208);
      check("j1_ow", 32'(full_output_width), 32'd3);
      check("j1_oh", 32'(full_output_height), 32'd3);
      check("j1_desc", 32'(nmcu_desc), 32'hABCD);
      wait_done(300);

      // 6x6 K=2: 25 pixels, 3 waves; cmd_valid pulsed mid-job must be ignored.
      submit(6, 6, 2, 'h0100, 'h0200, 'h1234);
      wait_start(50);
      cmd_input_width = DW'(9);
      cmd_valid = 1'b1;
      tick();
      check("busy_not_ready", 32'(cmd_ready), 32'd0);
      cmd_valid = 1'b0;
      tick();
      check("dims_unchanged", 32'(full_input_width), 32'd6);
      begin
         int t = 0;
         while (!(wave_idx == 2 && start != '0) && t < 500) begin tick(); t++; end
         check("j2_wave3_reached", 32'(wave_idx), 32'd2);
         check("j2_w3_in0", 32'(input_addr[0 +: AW]), 32'h0115);
         check("j2_w3_out0", 32'(output_addr[0 +: AW]), 32'h0212);
      end
      wait_done(500);

      // K > W: rejected with exact timing, no start.
      submit(6, 6, 7, 'h0100, 'h0200, 0);
      check("err_busy", 32'(busy), 32'd1);
      check("err_no_done_yet", 32'(job_done), 32'd0);
      tick();
      check("err_job_done", 32'(job_done), 32'd1);
      check("err_job_err", 32'(job_err), 32'd1);
      check("err_no_start", 32'(start), 32'd0);
      tick();
      check("err_idle", 32'(busy), 32'd0);

      submit(6, 6, 0, 'h0100, 'h0200, 0);
      wait_done(10);
      submit(9, 4, 5, 'h0100, 'h0200, 0);
      wait_done(10);
      submit(16, 6, 3, 'h0100, 'h0200, 0);
      wait_done(10);

      // Address wrap modulo 2^16.
      submit(3, 3, 1, 'hFFFE, 'hFFFC, 0);
      wait_start(50);
      check("wrap_in2", 32'(input_addr[2*AW +: AW]), 32'h0000);
      check("wrap_out4", 32'(output_addr[4*AW +: AW]), 32'h0000);
      wait_done(300);

      // Non-square: 7x5 K=3 -> 5x3 output, 2 waves.
      submit(7, 5, 3, 'h0040, 'h0080, 0);
      wait_done(500);

      // Lane 2 done held: dispatcher must sit in RELEASE without a new wave.
      hold_mask = N'(4);
      submit(6, 6, 2, 'h0300, 'h0400, 0);
      wait_start(50);
      begin
         int t = 0;
         while (start != '0 && t < 100) begin tick(); t++; end
         check("hold_start_dropped", 32'(start), 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         check("hold_no_start", 32'(start), 32'd0);
         check("hold_busy", 32'(busy), 32'd1);
      end
      check("hold_wave_idx", 32'(wave_idx), 32'd0);
      hold_mask = '0;
      wait_done(500);

      // Reset while lanes are working, then a clean job.
      for (int k = 0; k < N; k++) lat[k] = 40;
      submit(6, 6, 4, 'h0100, 'h0200, 'h55AA);
      wait_start(50);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("abort_start", 32'(start), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_desc", 32'(nmcu_desc), 32'd0);
      rst = 1'b1;
      for (int k = 0; k < N; k++) lat[k] = 2 + k;
      tick();
      submit(6, 6, 4, 'h0100, 'h0200, 'h55AA);
      wait_done(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/conv_tile_dispatcher.md
Name: conv_tile_dispatcher

Overview:
- Upstream control stage for the NMCU array: accepts one convolution job (input/output base, feature-map dims, kernel dim, descriptor pointer).
- Computes each output pixel's input window address and output address, then drives per-NMCU address, start and shared geometry signals.
- Collects per-NMCU done; replaces hard-wired testbench address tables.
- Jobs with more output pixels than NUM_NMCUS are split into sequential waves in raster order.

Parameters:
ADDR_WIDTH, 16, address width of all addresses.
NUM_NMCUS, 9, number of NMCU lanes driven.
MAX_INPUT_DIM, 15, largest legal input width/height.
MAX_KERNEL_DIM, 7, largest legal kernel dim.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-low reset.
cmd_valid  in  1  job request.
cmd_ready  out  1  high only in IDLE.
cmd_input_base  in  ADDR_WIDTH  address of input[0][0].
cmd_output_base  in  ADDR_WIDTH  address of output[0][0].
cmd_input_width  in  $clog2(MAX_INPUT_DIM)+1  input columns.
cmd_input_height  in  $clog2(MAX_INPUT_DIM)+1  input rows.
cmd_kernel_dim  in  $clog2(MAX_KERNEL_DIM)+1  square kernel side.
cmd_desc  in  ADDR_WIDTH  descriptor list address.
nmcu_desc  out  ADDR_WIDTH  registered cmd_desc, shared by all lanes.
input_addr  out  NUM_NMCUS*ADDR_WIDTH  lane k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
output_addr  out  NUM_NMCUS*ADDR_WIDTH  same packing.
full_input_width / full_input_height  out  $clog2(MAX_INPUT_DIM)+1 each  latched input dims.
full_output_width / full_output_height  out  $clog2(MAX_INPUT_DIM)+1 each  W-K+1, H-K+1.
start  out  NUM_NMCUS  per-lane start level.
done  in  NUM_NMCUS  per-lane done level.
busy  out  1  high outside IDLE.
job_done  out  1  one-cycle pulse at job end.
job_err  out  1  valid with job_done; 1 = rejected job.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; start=0; all address and dim outputs 0; nmcu_desc=0; busy=0; job_done=0; job_err=0; cmd_ready=1 once reset releases. Reset mid-job aborts immediately; start drops the next edge.
- IDLE: cmd_valid&&cmd_ready latches all cmd_* fields -> CHECK.
- CHECK (1 cycle): error if K=0, K>MAX_KERNEL_DIM, W or H >MAX_INPUT_DIM, K>W or K>H. Error -> FINISH with err=1 and no start. Otherwise compute OW=W-K+1, OH=H-K+1; clear row/col counters (r,c) -> ASSIGN.
- ASSIGN: one lane per cycle, lane index l from 0.
  - Lane l gets input_addr = in_base + r*W + c and output_addr = out_base + r*OW + c, both mod 2^ADDR_WIDTH (wrap, no error).
  - Set active_mask[l]; advance c, wrapping to 0 with r+1 at c=OW-1.
  - Stop when l=NUM_NMCUS-1 or last pixel (r=OH-1,c=OW-1) assigned -> ISSUE.
  - Unassigned lanes: address 0, mask 0.
- ISSUE (1 cycle): start <= active_mask; clear done_seen -> WAIT.
- WAIT: done_seen |= done & active_mask. When a lane's done_seen sets, its start drops next cycle. When done_seen==active_mask -> RELEASE.
- RELEASE: start=0. Wait until (done & active_mask)==0, so stale done cannot complete the next wave. Then more pixels -> ASSIGN with l=0 and mask cleared; else -> FINISH.
- FINISH (1 cycle): job_done=1, job_err=err -> IDLE.
- Output address/dim signals are stable from ASSIGN end through RELEASE.
- Wave count = ceil(OW*OH/NUM_NMCUS).
- Latency, 1x1 output, 1 wave: 1 accept + 1 CHECK + 1 ASSIGN + 1 ISSUE + NMCU time + RELEASE + 1 FINISH.
- cmd_valid while busy is ignored (cmd_ready=0).
- done on inactive lanes is ignored.

Optional Feature:
- Macro DISPATCH_PERF_EN.
- Defined: adds output perf_cycles[31:0], cleared at job accept and incremented every cycle busy=1, saturating at 0xFFFFFFFF; it holds its value in IDLE and is zeroed by reset. Also adds perf_waves[7:0], the number of ISSUE states in the last job.
- Undefined: neither port nor counter exists.

Test Plan:
- 6x6 input, K=4, in_base 0x0100, out_base 0x0200, NUM_NMCUS=9 -> one wave, all 9 starts high. Lane addresses: 0x0100,0x0101,0x0102,0x0106..0x0108,0x010C..0x010E; outputs 0x0200..0x0208; full_output 3x3; one job_done, job_err=0.
- Same job with NUM_NMCUS=4 -> 3 waves with masks 0xF, 0xF, 0x1. Wave-3 lane0 input 0x010E, output 0x0208. Starts never overlap across waves.
- K=7, W=H=6 -> job_done with job_err=1 two cycles after accept; start never asserted.
- Lane 2 done held high through RELEASE -> state stays RELEASE, no new ISSUE, until it drops.
- rst=0 during WAIT -> next edge start=0, busy=0, cmd_ready=1; a new job then completes normally.
- cmd_valid pulsed mid-job -> ignored; latched dims unchanged.
